// File: rtl/stream_run_seq.sv
// Run sequencer: accepts one run command, drives a clean start edge to the stream units and
// reports completion, status and run length once every unit has freshly finished.
module stream_run_seq #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned IDLE_CYC  = 2,
    parameter int unsigned ARM_CYC   = 3,
    parameter int unsigned TIMEOUT   = 65535,
    parameter int unsigned CW        = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [31:0]          cmd_n_i,
    input  logic                 abort_i,
    output logic [31:0]          run_n_o,
    output logic                 run_start_o,
    input  logic [NUM_UNITS-1:0] unit_finish_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [1:0]           status_o,
    output logic [CW-1:0]        cycles_o
);

    localparam int unsigned CntW = 8;
    localparam logic [CntW-1:0] PreLast = CntW'(IDLE_CYC - 1);
    localparam logic [CntW-1:0] ArmLast = CntW'(ARM_CYC - 1);

    localparam logic [1:0] StatOk    = 2'b00;
    localparam logic [1:0] StatTmo   = 2'b01;
    localparam logic [1:0] StatZero  = 2'b10;
    localparam logic [1:0] StatAbort = 2'b11;

    typedef enum logic [2:0] {StIdle, StPre, StArm, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       run_n_q, run_n_d;
    logic              run_start_q, run_start_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        status_q, status_d;
    logic [CW-1:0]     cycles_q, cycles_d;

    logic accept;
    logic all_fin;
    logic timeout_hit;
    logic [CW-1:0] cycles_inc;

    assign cmd_ready_o = (state_q == StIdle) && !rst_i;
    assign accept      = cmd_valid_i && cmd_ready_o;
    assign all_fin     = &unit_finish_i;
    assign timeout_hit = (TIMEOUT != 0) && (cycles_q == CW'(TIMEOUT));
    assign cycles_inc  = (&cycles_q) ? cycles_q : cycles_q + CW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            run_n_q     <= '0;
            run_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= StatOk;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            run_n_q     <= run_n_d;
            run_start_q <= run_start_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            status_q    <= status_d;
            cycles_q    <= cycles_d;
        end
    end

    // Abort beats timeout beats completion; unit_finish is only looked at in WAIT.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = (cmd_n_i == '0) ? StDone : StPre;
            end
            StPre: begin
                if (abort_i)              state_d = StDone;
                else if (cnt_q == PreLast) state_d = StArm;
            end
            StArm, StWait: begin
                if (abort_i || timeout_hit)              state_d = StDone;
                else if (state_q == StWait && all_fin)   state_d = StDone;
                else if (state_q == StArm && cnt_q == ArmLast) state_d = StWait;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        run_n_d     = run_n_q;
        run_start_d = run_start_q;
        status_d    = status_q;
        cycles_d    = cycles_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    run_n_d  = cmd_n_i;
                    cnt_d    = '0;
                    cycles_d = '0;
                    // A zero-length run leaves run_start untouched.
                    if (cmd_n_i == '0) status_d = StatZero;
                    else               run_start_d = 1'b0;
                end
            end
            StPre: begin
                if (abort_i) begin
                    status_d = StatAbort;
                end else if (cnt_q == PreLast) begin
                    cnt_d       = '0;
                    run_start_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StArm, StWait: begin
                if (abort_i) begin
                    status_d    = StatAbort;
                    run_start_d = 1'b0;
                end else if (timeout_hit) begin
                    status_d    = StatTmo;
                    run_start_d = 1'b0;
                end else if (state_q == StWait && all_fin) begin
                    status_d = StatOk;
                end else begin
                    cycles_d = cycles_inc;
                    if (state_q == StArm) cnt_d = cnt_q + CntW'(1);
                end
            end
            default: ;
        endcase
        busy_d = (state_d == StPre) || (state_d == StArm) || (state_d == StWait);
        done_d = (state_d == StDone);
    end

    assign run_n_o     = run_n_q;
    assign run_start_o = run_start_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign status_o    = status_q;
    assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_stream_run_seq.sv
// Bench for stream_run_seq: each run's whole timeline is predicted from the command, the finish
// waveform and the abort time, then compared cycle by cycle against the DUT outputs.
module tb_stream_run_seq;

    localparam int unsigned NU = 4;
    localparam int unsigned IC = 2;
    localparam int unsigned AC = 3;
    localparam int unsigned TO = 100;
    localparam int unsigned CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [31:0]   cmd_n;
    logic          abort;
    logic [31:0]   run_n;
    logic          run_start;
    logic [NU-1:0] unit_finish;
    logic          busy;
    logic          done;
    logic [1:0]    status;
    logic [CW-1:0] cycles;

    always #5 clk = ~clk;

    stream_run_seq #(
        .NUM_UNITS(NU),
        .IDLE_CYC (IC),
        .ARM_CYC  (AC),
        .TIMEOUT  (TO),
        .CW       (CW)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_n_i      (cmd_n),
        .abort_i      (abort),
        .run_n_o      (run_n),
        .run_start_o  (run_start),
        .unit_finish_i(unit_finish),
        .busy_o       (busy),
        .done_o       (done),
        .status_o     (status),
        .cycles_o     (cycles)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int          cyc = 0;
    int          last_done = -10;
    bit          prev_rs = 1'b0;

    // Scenario of the run in flight; times are cycles after the accept cycle.
    int sc_r;
    int sc_fin;
    bit sc_stale;
    bit sc_stuck;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [NU-1:0] fin_at(input int k);
        int rr = k - sc_r;
        logic [NU-1:0] all = '1;
        if (sc_stuck) all[2] = 1'b0;
        if (sc_stale) begin
            if (rr < int'(AC)) return '1;
            if (rr < int'(AC) + sc_fin) return '0;
            return all;
        end
        return (rr >= sc_fin) ? all : '0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_run_n"}, run_n, 0);
        check_eq({tag, "_run_start"}, run_start, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_status"}, status, 0);
        check_eq({tag, "_cycles"}, cycles, 0);
    endtask

    task automatic run_case(input logic [31:0] n, input int fin, input bit stale,
                            input bit stuck, input int ab, input bit b2b);
        int e;
        int st;
        int bud;
        logic exp_rs;
        sc_r     = IC + 1;
        sc_fin   = fin;
        sc_stale = stale;
        sc_stuck = stuck;
        cmd_valid = 1'b1;
        cmd_n     = n;
        abort     = 1'b0;
        if (stale) unit_finish = '1;
        bud = 0;
        while (!cmd_ready && bud < 20) begin
            tick;
            bud++;
        end
        check_eq("accept_ready", cmd_ready, 1);
        if (b2b) check_eq("b2b_gap", cyc - last_done, 1);
        unit_finish = fin_at(0);

        // Timeline prediction: first cycle at which a terminating event applies, by priority.
        e  = -1;
        st = 0;
        if (n == 0) begin
            e  = 0;
            st = 2;
        end else begin
            for (int k = 1; k < 1000 && e < 0; k++) begin
                if (k == ab) begin
                    e = k; st = 3;
                end else if (k >= sc_r && TO != 0 && k - sc_r == int'(TO)) begin
                    e = k; st = 1;
                end else if (k >= sc_r + int'(AC) && (&fin_at(k))) begin
                    e = k; st = 0;
                end
            end
        end

        for (int k = 1; k <= e + 1; k++) begin
            tick;
            if (n == 0)      exp_rs = prev_rs;
            else if (k < sc_r) exp_rs = 1'b0;
            else if (k <= e)   exp_rs = 1'b1;
            else               exp_rs = (st == 0);
            check_eq("done", done, k == e + 1);
            check_eq("busy", busy, k <= e);
            check_eq("run_start", run_start, exp_rs);
            check_eq("run_n", run_n, n);
            check_eq("cmd_ready_busy", cmd_ready, 0);
            if (n != 0) begin
                if (k <= e) check_eq("cycles", cycles, (k >= sc_r) ? k - sc_r : 0);
                else        check_eq("cycles_done", cycles, (e >= sc_r) ? e - sc_r : 0);
            end
            if (k == e + 1) check_eq("status", status, st);
            cmd_valid   = 1'b0;
            unit_finish = fin_at(k);
            abort       = (k == ab);
        end
        last_done = cyc;
        if (n != 0) prev_rs = (st == 0);
    endtask

    task automatic reset_mid_wait;
        sc_r = IC + 1; sc_fin = 1000; sc_stale = 1'b0; sc_stuck = 1'b0;
        cmd_valid = 1'b1; cmd_n = 32'd9; abort = 1'b0; unit_finish = '0;
        for (int b = 0; b < 20 && !cmd_ready; b++) tick;
        check_eq("rst_accept_ready", cmd_ready, 1);
        for (int k = 1; k <= int'(IC + 1 + AC) + 5; k++) begin
            tick;
            cmd_valid = 1'b0;
        end
        check_eq("rst_pre_busy", busy, 1);
        rst = 1'b1;
        tick;
        check_reset_outputs("rst_mid");
        check_eq("rst_mid_ready", cmd_ready, 0);
        rst = 1'b0;
        tick;
        check_reset_outputs("rst_after");
        check_eq("rst_after_ready", cmd_ready, 1);
        prev_rs = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        rst = 1'b1; cmd_valid = 1'b0; cmd_n = '0; abort = 1'b0; unit_finish = '0;
        tick;
        tick;
        check_reset_outputs("reset");
        check_eq("reset_ready", cmd_ready, 0);
        rst = 1'b0;
        tick;
        check_eq("post_reset_ready", cmd_ready, 1);

        run_case(32'd20, 50, 1'b0, 1'b0, -1, 1'b0);   // normal run, cycles=50
        run_case(32'd0, 0, 1'b0, 1'b0, -1, 1'b0);     // zero length
        run_case(32'd13, 10, 1'b0, 1'b1, -1, 1'b0);   // unit 2 stuck: timeout
        run_case(32'd6, 5, 1'b0, 1'b0, -1, 1'b0);
        run_case(32'd8, 10, 1'b1, 1'b0, -1, 1'b0);    // stale finish through ARM
        run_case(32'd30, 80, 1'b0, 1'b0, 30, 1'b0);   // abort in WAIT
        reset_mid_wait();
        run_case(32'd5, 4, 1'b0, 1'b0, -1, 1'b0);
        run_case(32'd7, 4, 1'b0, 1'b0, -1, 1'b1);     // back-to-back
        run_case(32'd11, 0, 1'b0, 1'b0, 2, 1'b0);     // abort in PRE

        for (int i = 0; i < 40; i++) begin
            logic [31:0] n;
            int fin, ab;
            bit stale, stuck;
            n     = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            fin   = $urandom_range(0, 60);
            stale = ($urandom_range(0, 3) == 0);
            stuck = ($urandom_range(0, 5) == 0);
            ab    = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 60)) : -1;
            gap   = $urandom_range(0, 3);
            cmd_valid = 1'b0;
            abort     = 1'b0;
            repeat (gap) tick;
            run_case(n, fin, stale, stuck, ab, gap == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
